vmem_rect_fill: RTL
===================

Name: vmem_rect_fill

Overview:
- Memory-mapped rectangle-fill engine on the CPU data bus. It sits directly upstream of the 3-bit-per-pixel video memory and feeds its write port.
- Software programs origin, size and colour, then starts a fill. The engine writes one pixel per cycle into vmem, using address {y[7:0], x[7:0]}.
- This offloads CPU store loops. The display scan-out side is unchanged.

Parameters:
- MAX_X, 239, largest visible column; writes with x > MAX_X are suppressed.
- MAX_Y, 239, largest visible row; writes with y > MAX_Y are suppressed.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- cfg_we_i  in  1  register write strobe (dbus write decoded to this block)
- cfg_addr_i  in  4  byte offset: 0x0 ORIGIN, 0x4 SIZE, 0x8 COLOR, 0xC CTRL/STATUS
- cfg_wdata_i  in  32  register write data
- cfg_rdata_o  out  32  register read data, registered, 1-cycle latency
- vmem_ready_i  in  1  vmem port free this cycle (low when CPU stores to vmem)
- vmem_we_o  out  1  pixel write strobe
- vmem_waddr_o  out  16  {y, x}
- vmem_wdata_o  out  3  colour {R, G, B}
- busy_o  out  1  fill in progress
- done_o  out  1  one-cycle pulse at completion or abort

Behaviour:
- Reset (async, rst_i=1) sets:
  - outputs: busy_o=0, done_o=0, cfg_rdata_o=0, vmem_we_o=0, vmem_waddr_o=0, vmem_wdata_o=0;
  - internal: all config registers=0, state=IDLE, DONE flag=0.
- Registers:
  - ORIGIN: [7:0] x0, [15:8] y0.
  - SIZE: [8:0] w, [24:16] h; range 0..256 each.
  - COLOR: [2:0].
  - CTRL write: bit0 START, bit1 ABORT, bit2 CLR_DONE.
  - CTRL read: bit0 busy, bit1 DONE sticky.
  - ORIGIN, SIZE and COLOR read back their written value.
  - Unused bits read 0.
- Shadowing: START latches x0, y0, w, h and colour into working registers. Config writes during RUN change only the visible registers; they do not affect the active fill.
- FSM states IDLE and RUN:
  - IDLE with START: if w==0 or h==0, stay IDLE, pulse done_o on the next cycle and set DONE. Otherwise go to RUN next cycle with x=x0, y=y0, busy_o=1.
  - RUN, per cycle with vmem_ready_i=1: the current pixel is issued.
    - Issue order: x advances first; at x==x0+w-1, x returns to x0 and y increments.
    - After pixel (x0+w-1, y0+h-1), go to IDLE, pulse done_o and set DONE.
  - RUN with vmem_ready_i=0: hold x, y and state; vmem_we_o=0.
  - START while RUN: ignored.
  - ABORT while RUN: go to IDLE next cycle, no further writes, pulse done_o and set DONE. ABORT in IDLE: no effect.
  - START and ABORT written together: ABORT wins in RUN; START wins in IDLE.
  - CLR_DONE clears DONE. If it coincides with completion, set wins.
- vmem write signals are combinational from the working registers:
  - vmem_we_o = RUN & vmem_ready_i & (x<=MAX_X) & (y<=MAX_Y).
  - vmem_waddr_o = {y[7:0], x[7:0]}; vmem_wdata_o = latched colour.
- Clipped pixels still consume a cycle, so fill time does not depend on clipping.
- Counter width: x and y counters are 9 bits (x0+w-1 ≤ 510), so there is no wrap-around to column 0.
- Latency: START written in cycle N → first vmem_we_o in cycle N+1 → done_o in cycle N+1+w*h, assuming no stalls.
- Reset mid-fill: immediate return to IDLE, no done_o pulse.

Decomposition:
- Package vmem_rect_fill_pkg holds:
  - register offsets (ORIGIN/SIZE/COLOR/CTRL);
  - CTRL bit indices;
  - the state encoding localparams (IDLE=0, RUN=1);
  - the default MAX_X/MAX_Y.
- One sub-module, rect_scan: the 9-bit x/y raster counter with load/advance/last outputs. The top keeps the FSM, register file and clipping.

Test Plan:
- Basic fill.
  - Stimulus: ORIGIN=0x140A, SIZE w=4 h=2, COLOR=5, START, vmem_ready_i=1.
  - Response: 8 writes in order 0x140A..0x140D, then 0x150A..0x150D, all wdata=5. done_o exactly 9 cycles after the START write.
- Right/bottom clip.
  - Stimulus: x0=238, y0=239, w=4, h=2.
  - Response: writes only to 0xEFEE and 0xEFEF; no writes for x≥240 or y=240. done_o after 8 pixel cycles.
- Empty and maximum size.
  - Stimulus 1: w=0, h=5 → no vmem_we_o; done_o one cycle after START; STATUS reads 0x2.
  - Stimulus 2: w=h=256 from (0,0) → exactly 57600 writes.
- Stall.
  - Stimulus: vmem_ready_i held low for 3 cycles mid-fill of a 3x1 rectangle.
  - Response: no write and x held during the stall; sequence resumes without skip or duplicate; completion delayed by exactly 3 cycles.
- Abort and shadowing.
  - Stimulus: rewrite COLOR=2 during an active fill of COLOR=7, then ABORT after 5 pixels.
  - Response: all 5 writes carry 7; writes stop the next cycle; done_o pulses; a new START then uses colour 2.
- Reset mid-operation.
  - Stimulus: assert rst_i asynchronously during RUN.
  - Response: vmem_we_o, busy_o and done_o drop immediately; STATUS reads 0 after release.

Source files
------------

// File: rtl/vmem_rect_fill_pkg.sv
// Shared constants for the vmem rectangle-fill engine: register map, CTRL bits,
// FSM encoding and default visible-area limits.
package vmem_rect_fill_pkg;

   localparam logic [3:0] REG_ORIGIN = 4'h0;
   localparam logic [3:0] REG_SIZE   = 4'h4;
   localparam logic [3:0] REG_COLOR  = 4'h8;
   localparam logic [3:0] REG_CTRL   = 4'hC;

   localparam int CTRL_START    = 0;
   localparam int CTRL_ABORT    = 1;
   localparam int CTRL_CLR_DONE = 2;

   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int DEF_MAX_X = 239;
   localparam int DEF_MAX_Y = 239;

endpackage

// File: rtl/vmem_rect_fill_scan.sv
// 9-bit raster counter for the fill engine: x advances first, then y.
// Holds its own copy of the origin and end coordinates from the load cycle.
module rect_scan (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       load,
   input  logic       advance,
   input  logic [7:0] x0,
   input  logic [7:0] y0,
   input  logic [8:0] w,
   input  logic [8:0] h,
   output logic [8:0] x,
   output logic [8:0] y,
   output logic       last
);

   logic [8:0] x0_q;
   logic [8:0] x_end_q;
   logic [8:0] y_end_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         x       <= '0;
         y       <= '0;
         x0_q    <= '0;
         x_end_q <= '0;
         y_end_q <= '0;
      end else if (load) begin
         x       <= {1'b0, x0};
         y       <= {1'b0, y0};
         x0_q    <= {1'b0, x0};
         // Largest end coordinate is 255 + 256 - 1 = 510, so 9 bits never wrap.
         x_end_q <= {1'b0, x0} + w - 9'd1;
         y_end_q <= {1'b0, y0} + h - 9'd1;
      end else if (advance) begin
         if (x == x_end_q) begin
            x <= x0_q;
            y <= y + 9'd1;
         end else begin
            x <= x + 9'd1;
         end
      end
   end

   assign last = (x == x_end_q) && (y == y_end_q);

endmodule

// File: rtl/vmem_rect_fill.sv
// Memory-mapped rectangle-fill engine: register file, IDLE/RUN control FSM
// and clipping in front of the 3-bit-per-pixel video memory write port.
module vmem_rect_fill
   import vmem_rect_fill_pkg::*;
#(
   parameter int MAX_X = DEF_MAX_X,
   parameter int MAX_Y = DEF_MAX_Y
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cfg_we_i,
   input  logic [3:0]  cfg_addr_i,
   input  logic [31:0] cfg_wdata_i,
   output logic [31:0] cfg_rdata_o,
   input  logic        vmem_ready_i,
   output logic        vmem_we_o,
   output logic [15:0] vmem_waddr_o,
   output logic [2:0]  vmem_wdata_o,
   output logic        busy_o,
   output logic        done_o
);

   localparam logic [8:0] MAX_X9 = 9'(MAX_X);
   localparam logic [8:0] MAX_Y9 = 9'(MAX_Y);

   state_e      state_q, state_d;
   logic [7:0]  x0_q, y0_q;
   logic [8:0]  w_q, h_q;
   logic [2:0]  color_q;
   logic [2:0]  color_w_q;
   logic        done_flag_q;
   logic        done_set;
   logic        scan_load, scan_adv, scan_last;
   logic [8:0]  scan_x, scan_y;
   logic        ctrl_wr, start, abort, clr_done;
   logic [31:0] rdata_d;
   logic        unused_wdata;

   assign ctrl_wr  = cfg_we_i && (cfg_addr_i == REG_CTRL);
   assign start    = ctrl_wr && cfg_wdata_i[CTRL_START];
   assign abort    = ctrl_wr && cfg_wdata_i[CTRL_ABORT];
   assign clr_done = ctrl_wr && cfg_wdata_i[CTRL_CLR_DONE];
   assign unused_wdata = ^cfg_wdata_i[31:25];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         x0_q    <= '0;
         y0_q    <= '0;
         w_q     <= '0;
         h_q     <= '0;
         color_q <= '0;
      end else if (cfg_we_i) begin
         case (cfg_addr_i)
            REG_ORIGIN: begin
               x0_q <= cfg_wdata_i[7:0];
               y0_q <= cfg_wdata_i[15:8];
            end
            REG_SIZE: begin
               w_q <= cfg_wdata_i[8:0];
               h_q <= cfg_wdata_i[24:16];
            end
            REG_COLOR: color_q <= cfg_wdata_i[2:0];
            default: ;
         endcase
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      scan_load = 1'b0;
      scan_adv  = 1'b0;
      done_set  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (w_q == 9'd0 || h_q == 9'd0) begin
                  done_set = 1'b1;
               end else begin
                  state_d   = ST_RUN;
                  scan_load = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d  = ST_IDLE;
               done_set = 1'b1;
            end else if (vmem_ready_i) begin
               scan_adv = 1'b1;
               if (scan_last) begin
                  state_d  = ST_IDLE;
                  done_set = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         done_o      <= 1'b0;
         done_flag_q <= 1'b0;
         color_w_q   <= '0;
         cfg_rdata_o <= '0;
      end else begin
         state_q     <= state_d;
         done_o      <= done_set;
         cfg_rdata_o <= rdata_d;
         if (scan_load) color_w_q <= color_q;
         // Completion in the same cycle as CLR_DONE leaves DONE set.
         if (done_set)      done_flag_q <= 1'b1;
         else if (clr_done) done_flag_q <= 1'b0;
      end
   end

   always_comb begin
      rdata_d = '0;
      case (cfg_addr_i)
         REG_ORIGIN: rdata_d[15:0] = {y0_q, x0_q};
         REG_SIZE: begin
            rdata_d[8:0]   = w_q;
            rdata_d[24:16] = h_q;
         end
         REG_COLOR: rdata_d[2:0] = color_q;
         REG_CTRL: begin
            rdata_d[STAT_BUSY] = (state_q == ST_RUN);
            rdata_d[STAT_DONE] = done_flag_q;
         end
         default: ;
      endcase
   end

   rect_scan u_scan (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load    (scan_load),
      .advance (scan_adv),
      .x0      (x0_q),
      .y0      (y0_q),
      .w       (w_q),
      .h       (h_q),
      .x       (scan_x),
      .y       (scan_y),
      .last    (scan_last)
   );

   // Clipped pixels still take their cycle; only the strobe is suppressed.
   assign busy_o       = (state_q == ST_RUN);
   assign vmem_we_o    = busy_o && vmem_ready_i && (scan_x <= MAX_X9) && (scan_y <= MAX_Y9);
   assign vmem_waddr_o = {scan_y[7:0], scan_x[7:0]};
   assign vmem_wdata_o = color_w_q;

endmodule
